// File: rtl/hough_pixel_sequencer.sv
// hough_pixel_sequencer
//
// Walks a binary edge map stored one pixel per address, in raster order, from
// a synchronous-read block RAM. Each edge pixel is handed to the Hough
// transformer as (x, y) with a one-cycle start pulse. The sequencer then waits
// for the transformer's done pulse, or gives up after TIMEOUT_CYCLES, before it
// moves on. One frame_start scans one frame. The scan ends with a single-cycle
// frame_done pulse, and the number of edge pixels dispatched is left on
// edge_count.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   frame_start  one-cycle request to scan a frame (honoured only when idle)
//   busy         high from the cycle after an accepted frame_start until idle
//   frame_done   one-cycle pulse when the scan completes
//   edge_count   edge pixels dispatched this frame, held after the scan
//   timeout_err  sticky per frame: some pixel was abandoned on timeout
//   mem_addr     edge-map read address (registered)
//   mem_data     edge bit, valid one cycle after mem_addr changes
//   xform_x      x coordinate to the transformer, held while waiting
//   xform_y      y coordinate to the transformer, held while waiting
//   xform_start  one-cycle start pulse to the transformer
//   xform_done   one-cycle completion pulse from the transformer
module hough_pixel_sequencer #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] edge_count,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic [9:0]        xform_x,
    output logic [8:0]        xform_y,
    output logic              xform_start,
    input  logic              xform_done
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0]      X_LAST  = 10'(H_RES - 1);
    localparam logic [8:0]      Y_LAST  = 9'(V_RES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SAMPLE,
        WAIT_XF,
        ADVANCE,
        DONE
    } state_t;

    state_t          state;
    logic [9:0]      x;
    logic [8:0]      y;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            xform_start <= 1'b0;
            timeout_err <= 1'b0;
            edge_count  <= '0;
            mem_addr    <= '0;
            xform_x     <= '0;
            xform_y     <= '0;
            x           <= '0;
            y           <= '0;
            to_cnt      <= '0;
        end else begin
            // Both pulses last one cycle unless a state sets them again.
            xform_start <= 1'b0;
            frame_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= FETCH;
                        busy        <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        mem_addr    <= '0;
                        edge_count  <= '0;
                        timeout_err <= 1'b0;
                    end
                end

                // The RAM registers mem_addr during this cycle, so its data
                // appears in SAMPLE.
                FETCH: begin
                    state <= SAMPLE;
                end

                SAMPLE: begin
                    if (mem_data) begin
                        xform_x     <= x;
                        xform_y     <= y;
                        xform_start <= 1'b1;
                        edge_count  <= edge_count + 1'b1;
                        to_cnt      <= '0;
                        state       <= WAIT_XF;
                    end else begin
                        state <= ADVANCE;
                    end
                end

                // The timeout counter holds k during the (k+1)-th wait cycle.
                // The last cycle allowed is therefore TO_LAST. A done pulse in
                // that same cycle is tested first, so it counts as a normal
                // completion.
                WAIT_XF: begin
                    if (xform_done) begin
                        state <= ADVANCE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ADVANCE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                // The address is not incremented after the last pixel, so
                // mem_addr stays within the map.
                ADVANCE: begin
                    if (x == X_LAST && y == Y_LAST) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        mem_addr <= mem_addr + 1'b1;
                        state    <= FETCH;
                    end
                end

                // frame_done is high during this cycle. A frame_start seen here
                // is dropped, because only IDLE accepts one.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hough_pixel_sequencer.sv
module tb_hough_pixel_sequencer;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int N    = H * V;
    localparam int AW   = 4;
    localparam int TO   = 64;
    localparam int MAXE = 4096;
    localparam int BIG  = 1 << 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] edge_count;
    logic          timeout_err;
    logic [AW-1:0] mem_addr;
    logic          mem_data;
    logic [9:0]    xform_x;
    logic [8:0]    xform_y;
    logic          xform_start;
    logic          xform_done;

    hough_pixel_sequencer #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .edge_count(edge_count),
        .timeout_err(timeout_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .xform_x(xform_x), .xform_y(xform_y), .xform_start(xform_start),
        .xform_done(xform_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge-map RAM: one-cycle read latency.
    bit map [N];
    always @(posedge clk) mem_data <= (int'(mem_addr) < N) ? map[mem_addr] : 1'b0;

    // Timeline model of one frame. Offset 0 is the IDLE cycle in which
    // frame_start is driven. From offset `cut` onward the expected values are
    // the post-reset state.
    bit e_busy [MAXE];
    bit e_start[MAXE];
    bit e_fd   [MAXE];
    bit e_te   [MAXE];
    int e_addr [MAXE];
    int e_x    [MAXE];
    int e_y    [MAXE];
    int e_ec   [MAXE];
    int base, len, cut, done_off;
    int fetch_off [N];
    int m_addr, m_ec, m_x, m_y;
    bit m_te;
    int lats[$];

    // Transformer model. Each start takes the next latency from rsp_q, and
    // latency -1 means done never arrives.
    int rsp_q[$];
    int rsp_cnt  = -1;
    bit rsp_flush = 1'b0;
    int spur_cyc = -1;

    always @(negedge clk) begin
        xform_done = 1'b0;
        if (rsp_flush) begin
            rsp_cnt   = -1;
            rsp_flush = 1'b0;
        end else if (xform_start === 1'b1) begin
            if (rsp_q.size() > 0) rsp_cnt = rsp_q.pop_front();
            else rsp_cnt = -1;
        end
        if (rsp_cnt == 0) xform_done = 1'b1;
        if (rsp_cnt >= 0) rsp_cnt--;
        if (cyc == spur_cyc) xform_done = 1'b1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int log_x[$];
    int log_y[$];
    int fd_cyc = -1;

    int c_off, c_addr, c_x, c_y, c_ec;
    bit c_busy, c_start, c_fd, c_te;

    always @(negedge clk) begin
        if (chk_en) begin
            c_off = cyc - base;
            if (c_off >= cut) begin
                c_busy = 0; c_start = 0; c_fd = 0; c_te = 0;
                c_addr = 0; c_x = 0; c_y = 0; c_ec = 0;
            end else begin
                if (c_off > len) c_off = len;
                c_busy = e_busy[c_off]; c_start = e_start[c_off];
                c_fd = e_fd[c_off]; c_te = e_te[c_off];
                c_addr = e_addr[c_off]; c_x = e_x[c_off];
                c_y = e_y[c_off]; c_ec = e_ec[c_off];
            end
            n_chk++;
            if (busy !== c_busy || frame_done !== c_fd || xform_start !== c_start ||
                timeout_err !== c_te || mem_addr !== AW'(c_addr) ||
                edge_count !== AW'(c_ec) || xform_x !== 10'(c_x) || xform_y !== 9'(c_y)) begin
                n_fail++;
                $display("FAIL cycle_check cyc=%0d off=%0d got busy=%b fd=%b st=%b te=%b addr=%0d ec=%0d x=%0d y=%0d want busy=%b fd=%b st=%b te=%b addr=%0d ec=%0d x=%0d y=%0d",
                         cyc, cyc - base, busy, frame_done, xform_start, timeout_err, mem_addr,
                         edge_count, xform_x, xform_y, c_busy, c_fd, c_start, c_te, c_addr,
                         c_ec, c_x, c_y);
            end
            if (xform_start === 1'b1) begin
                log_x.push_back(int'(xform_x));
                log_y.push_back(int'(xform_y));
            end
            if (frame_done === 1'b1) fd_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_entry(input int t, input bit b, input int a, input bit s,
                             input bit fd, input int ec, input bit te);
        e_busy[t] = b; e_addr[t] = a; e_start[t] = s; e_fd[t] = fd;
        e_ec[t] = ec; e_te[t] = te; e_x[t] = m_x; e_y[t] = m_y;
    endtask

    // Frame cost: a non-edge pixel takes FETCH, SAMPLE and ADVANCE. An edge
    // pixel also waits min(lat+1, TO) cycles, and reaching TO without done is
    // a timeout.
    task automatic build_frame();
        int t, ec, k, lat, w;
        bit te, ok;
        base = cyc;
        cut  = BIG;
        set_entry(0, 1'b0, m_addr, 1'b0, 1'b0, m_ec, m_te);
        t = 1; ec = 0; te = 1'b0; k = 0;
        for (int p = 0; p < N; p++) begin
            fetch_off[p] = t;
            set_entry(t, 1'b1, p, 1'b0, 1'b0, ec, te);
            set_entry(t + 1, 1'b1, p, 1'b0, 1'b0, ec, te);
            if (map[p]) begin
                m_x = p % H;
                m_y = p / H;
                ec++;
                lat = (k < lats.size()) ? lats[k] : -1;
                k++;
                ok = (lat >= 0) && (lat + 1 <= TO);
                w  = ok ? lat + 1 : TO;
                for (int i = 0; i < w; i++) set_entry(t + 2 + i, 1'b1, p, i == 0, 1'b0, ec, te);
                if (!ok) te = 1'b1;
                set_entry(t + 2 + w, 1'b1, p, 1'b0, 1'b0, ec, te);
                t += 3 + w;
            end else begin
                set_entry(t + 2, 1'b1, p, 1'b0, 1'b0, ec, te);
                t += 3;
            end
        end
        set_entry(t, 1'b1, N - 1, 1'b0, 1'b1, ec, te);
        set_entry(t + 1, 1'b0, N - 1, 1'b0, 1'b0, ec, te);
        done_off = t;
        len      = t + 1;
        m_addr = N - 1; m_ec = ec; m_te = te;
        rsp_q = lats;
    endtask

    task automatic launch();
        log_x.delete();
        log_y.delete();
        fd_cyc = -1;
        build_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame();
        wait_until(base + len + 2);
    endtask

    task automatic clear_map();
        for (int i = 0; i < N; i++) map[i] = 1'b0;
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return $urandom_range(0, 8);
        if (r == 6) return 62;
        if (r == 7) return 63;
        if (r == 8) return 64;
        return -1;
    endfunction

    int ones;

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        clear_map();
        m_addr = 0; m_ec = 0; m_x = 0; m_y = 0; m_te = 1'b0;
        base = 0; len = 0; cut = BIG;
        set_entry(0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_edge_count", int'(edge_count), 0);

        // All-zero map: 12 pixels x 3 cycles.
        clear_map();
        lats = {};
        launch();
        finish_frame();
        check_lit("zero_model_done_off", done_off - 1, 36);
        check_lit("zero_done_latency", fd_cyc - (base + 1), 36);
        check_lit("zero_edge_count", int'(edge_count), 0);
        check_lit("zero_starts", log_x.size(), 0);

        // Edges at 0, 5, 11 with done 46 cycles after each start.
        clear_map();
        map[0] = 1; map[5] = 1; map[11] = 1;
        lats = {46, 46, 46};
        launch();
        finish_frame();
        check_lit("three_done_latency", fd_cyc - (base + 1), 177);
        check_lit("three_starts", log_x.size(), 3);
        if (log_x.size() == 3) begin
            check_lit("start0_x", log_x[0], 0); check_lit("start0_y", log_y[0], 0);
            check_lit("start1_x", log_x[1], 1); check_lit("start1_y", log_y[1], 1);
            check_lit("start2_x", log_x[2], 3); check_lit("start2_y", log_y[2], 2);
        end
        check_lit("three_edge_count", int'(edge_count), 3);
        check_lit("three_timeout_err", int'(timeout_err), 0);

        // Transformer never answers: the pixel times out after 64 wait cycles.
        clear_map();
        map[6] = 1;
        lats = {-1};
        launch();
        finish_frame();
        check_lit("to_done_latency", fd_cyc - (base + 1), 100);
        check_lit("to_timeout_err", int'(timeout_err), 1);
        check_lit("to_edge_count", int'(edge_count), 1);

        // The next frame clears the sticky error.
        clear_map();
        lats = {};
        launch();
        tick();
        check_lit("to_cleared", int'(timeout_err), 0);
        finish_frame();

        // Done in the same cycle the timeout expires: done wins.
        clear_map();
        map[2] = 1;
        lats = {63};
        launch();
        finish_frame();
        check_lit("tie_timeout_err", int'(timeout_err), 0);
        check_lit("tie_done_latency", fd_cyc - (base + 1), 100);

        // frame_start mid-scan and in DONE; spurious done pulses in FETCH.
        clear_map();
        map[1] = 1; map[4] = 1; map[9] = 1;
        lats = {3, 0, 10};
        launch();
        spur_cyc = base + fetch_off[4];
        wait_until(base + 10);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_until(base + fetch_off[7]);
        spur_cyc = base + fetch_off[8];
        wait_until(base + done_off);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        finish_frame();
        repeat (4) tick();
        check_lit("ignore_edge_count", int'(edge_count), 3);
        check_lit("ignore_busy_after", int'(busy), 0);
        spur_cyc = -1;

        // Reset while waiting on the transformer.
        clear_map();
        map[1] = 1;
        lats = {-1};
        launch();
        wait_until(base + fetch_off[1] + 2 + 5);
        reset = 1'b1;
        cut = cyc + 1 - base;
        rsp_flush = 1'b1;
        m_addr = 0; m_ec = 0; m_x = 0; m_y = 0; m_te = 1'b0;
        tick();
        check_lit("rst_busy", int'(busy), 0);
        check_lit("rst_xform_start", int'(xform_start), 0);
        check_lit("rst_edge_count", int'(edge_count), 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check_lit("rst_no_frame_done", fd_cyc, -1);
        clear_map();
        lats = {};
        launch();
        finish_frame();

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            lats = {};
            ones = 0;
            for (int i = 0; i < N; i++) begin
                map[i] = ($urandom_range(0, 2) == 0);
                if (map[i]) begin
                    lats.push_back(pick_lat());
                    ones++;
                end
            end
            launch();
            finish_frame();
            check_lit("rand_edge_count", int'(edge_count), ones);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
